// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
//   loader_state_t  : loader FSM encoding (3 bits, exported on state_out)
//   SYNC_BYTE_DEFAULT : frame start marker
//   BYTES_PER_WORD  : bytes per instruction word at the default width
//   bytes_per_word(): same quantity for an arbitrary word width
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT   = 8'hA5;
    localparam int         INSTR_WIDTH_DEFAULT = 32;
    localparam int         BYTES_PER_WORD      = INSTR_WIDTH_DEFAULT / 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_COUNT = 3'd1,
        GET_DATA  = 3'd2,
        GET_CSUM  = 3'd3
    } loader_state_t;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/uart_imem_loader_if.sv
// Instruction fetch port between the controller and the loader.
//   rd_addr : fetch address, driven by the controller (master)
//   rd_data : instruction word, returned combinationally by the loader (slave)
interface uart_imem_loader_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32
);
    logic [PC_WIDTH-1:0]    rd_addr;
    logic [INSTR_WIDTH-1:0] rd_data;

    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/uart_imem_loader_rx.sv
// 8N1 UART receiver.
//   clk, rst_n : system clock, asynchronous active-low reset
//   rx_in      : serial line, idles high, asynchronous to clk
//   rx_valid   : one-cycle pulse, rx_byte holds a byte with a good stop bit
//   rx_byte    : received byte (LSB first on the line)
//   rx_ferr    : one-cycle pulse when the stop bit is sampled low
module uart_rx #(
    parameter int CLK_PER_BIT = 54
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam int            CW        = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);

    logic          meta_reg, sync_reg, prev_reg;
    logic [1:0]    rx_state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    data_reg;
    logic          valid_reg, ferr_reg;

    assign rx_valid = valid_reg;
    assign rx_ferr  = ferr_reg;
    assign rx_byte  = data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg     <= 1'b1;
            sync_reg     <= 1'b1;
            prev_reg     <= 1'b1;
            rx_state_reg <= RX_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            meta_reg  <= rx_in;
            sync_reg  <= meta_reg;
            prev_reg  <= sync_reg;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    // Edge detect rather than level: a line held low after a
                    // framing error must not retrigger a byte.
                    if (prev_reg && !sync_reg) begin
                        rx_state_reg <= RX_START;
                        cnt_reg      <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        // High again at mid start bit: glitch, drop it.
                        rx_state_reg <= sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg  <= '0;
                        data_reg <= {sync_reg, data_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            rx_state_reg <= RX_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg      <= '0;
                        rx_state_reg <= RX_IDLE;
                        if (sync_reg) valid_reg <= 1'b1;
                        else          ferr_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_imem_loader.sv
// Loads a framed program image from UART into instruction memory and serves
// the controller's fetch port.
// Frame: SYNC_BYTE, N, N words as bytes MSB first, CSUM (XOR of N and data).
// N = 0 means a full INSTR_DEPTH-word image.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   uart_rx      : serial input
//   fetch        : rd_addr in, rd_data = mem[rd_addr] out (combinational)
//   prog_busy    : high from SYNC_BYTE accepted until the frame ends
//   prog_done    : one-cycle pulse on a frame with a good checksum
//   prog_err     : sticky error, cleared by the next accepted SYNC_BYTE
//   words_loaded : words written in the current or last frame
//   state_out    : loader state for debug
module uart_imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         F_CLK       = 50_000_000,
    parameter int         BAUD        = 921_600,
    parameter int         CLK_PER_BIT = F_CLK / BAUD,
    parameter int         INSTR_WIDTH = 32,
    parameter int         INSTR_DEPTH = 256,
    parameter int         PC_WIDTH    = $clog2(INSTR_DEPTH),
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                uart_rx,
    uart_imem_loader_if.slave   fetch,
    output logic                prog_busy,
    output logic                prog_done,
    output logic                prog_err,
    output logic [PC_WIDTH:0]   words_loaded,
    output logic [2:0]          state_out
);
    localparam int             WORD_BYTES = bytes_per_word(INSTR_WIDTH);
    localparam int             BCW        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE  = BCW'(WORD_BYTES - 1);

    logic       rx_valid, rx_ferr;
    logic [7:0] rx_byte;

    uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (uart_rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    loader_state_t          state_reg;
    logic [PC_WIDTH:0]      n_reg, words_reg, words_next;
    logic [PC_WIDTH-1:0]    wr_addr_reg;
    logic [BCW-1:0]         byte_cnt_reg;
    logic [INSTR_WIDTH-9:0] shift_reg;     // leading bytes of the word in flight
    logic [7:0]             csum_reg;
    logic                   busy_reg, done_reg, err_reg;

    logic [INSTR_WIDTH-1:0] mem [INSTR_DEPTH];
    logic                   mem_we;
    logic [INSTR_WIDTH-1:0] wr_word;

    // The final byte of a word goes straight into memory on its rx_valid.
    assign mem_we     = (state_reg == GET_DATA) && rx_valid && (byte_cnt_reg == LAST_BYTE);
    assign wr_word    = {shift_reg, rx_byte};
    assign words_next = words_reg + (PC_WIDTH + 1)'(1);

    assign prog_busy    = busy_reg;
    assign prog_done    = done_reg;
    assign prog_err     = err_reg;
    assign words_loaded = words_reg;
    assign state_out    = state_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            n_reg        <= '0;
            words_reg    <= '0;
            wr_addr_reg  <= '0;
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
            csum_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (rx_ferr && (state_reg != IDLE)) begin
                // Abort; words already written are left in place.
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                err_reg   <= 1'b1;
            end else if (rx_valid) begin
                case (state_reg)
                    IDLE: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state_reg    <= GET_COUNT;
                            busy_reg     <= 1'b1;
                            err_reg      <= 1'b0;
                            words_reg    <= '0;
                            csum_reg     <= '0;
                            wr_addr_reg  <= '0;
                            byte_cnt_reg <= '0;
                        end
                    end
                    GET_COUNT: begin
                        n_reg     <= (rx_byte == 8'd0) ? (PC_WIDTH + 1)'(INSTR_DEPTH)
                                                       : (PC_WIDTH + 1)'(rx_byte);
                        csum_reg  <= csum_reg ^ rx_byte;
                        state_reg <= GET_DATA;
                    end
                    GET_DATA: begin
                        csum_reg <= csum_reg ^ rx_byte;
                        if (byte_cnt_reg == LAST_BYTE) begin
                            byte_cnt_reg <= '0;
                            wr_addr_reg  <= wr_addr_reg + PC_WIDTH'(1);
                            words_reg    <= words_next;
                            if (words_next == n_reg) state_reg <= GET_CSUM;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + BCW'(1);
                            shift_reg    <= {shift_reg[INSTR_WIDTH-17:0], rx_byte};
                        end
                    end
                    GET_CSUM: begin
                        if (rx_byte == csum_reg) done_reg <= 1'b1;
                        else                     err_reg  <= 1'b1;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr_reg] <= wr_word;
    end

    // Combinational fetch; a same-cycle write is seen only from the next cycle.
    assign fetch.rd_data = mem[fetch.rd_addr];

endmodule

// File: tb/tb_uart_imem_loader.sv
module tb_uart_imem_loader;
    import imem_loader_pkg::*;

    // Shortened bit time keeps the full-depth frame short in simulation.
    localparam int CPB = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       prog_busy, prog_done, prog_err;
    logic [8:0] words_loaded;
    logic [2:0] state_out;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [7:0] tb_csum;

    uart_imem_loader_if #(.PC_WIDTH(8), .INSTR_WIDTH(32)) fetch_if ();

    uart_imem_loader #(.CLK_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx      (uart_rx),
        .fetch        (fetch_if.slave),
        .prog_busy    (prog_busy),
        .prog_done    (prog_done),
        .prog_err     (prog_err),
        .words_loaded (words_loaded),
        .state_out    (state_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (prog_done) done_cnt <= done_cnt + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  flip;       // XORed into the transmitted checksum
        int          exp_done;   // prog_done pulses seen during the frame
        logic        exp_err;
        logic [8:0]  exp_words;
        logic [31:0] exp_m0;
        logic [31:0] exp_m1;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic send_bits(input logic [7:0] b);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            logic [7:0] b;
            b = w[i*8 +: 8];
            tb_csum = tb_csum ^ b;
            send_byte(b);
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        fetch_if.rd_addr = a;
        #1;
        d = fetch_if.rd_data;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int d0;
        logic [31:0] d;
        d0 = done_cnt;
        send_byte(8'hA5);
        tb_csum = v.n;
        send_byte(v.n);
        repeat (2) @(negedge clk);
        check($sformatf("v%0d_busy_mid", idx), 32'(prog_busy), 32'd1);
        check($sformatf("v%0d_state_mid", idx), 32'(state_out), 32'(GET_DATA));
        send_word(v.w0);
        if (v.n != 8'd1) send_word(v.w1);
        send_byte(tb_csum ^ v.flip);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_done", idx), 32'(done_cnt - d0), 32'(v.exp_done));
        check($sformatf("v%0d_err", idx), 32'(prog_err), 32'(v.exp_err));
        check($sformatf("v%0d_busy", idx), 32'(prog_busy), 32'd0);
        check($sformatf("v%0d_state", idx), 32'(state_out), 32'(IDLE));
        check($sformatf("v%0d_words", idx), 32'(words_loaded), 32'(v.exp_words));
        rd(8'd0, d);
        check($sformatf("v%0d_mem0", idx), d, v.exp_m0);
        rd(8'd1, d);
        check($sformatf("v%0d_mem1", idx), d, v.exp_m1);
    endtask

    initial begin
        logic [31:0] d;
        int d0;
        bit found;

        // n, w0, w1, flip, exp_done, exp_err, exp_words, exp_m0, exp_m1
        vecs[0] = '{8'h02, 32'h12345678, 32'hDEADBEEF, 8'h00, 1, 1'b0, 9'd2, 32'h12345678, 32'hDEADBEEF};
        vecs[1] = '{8'h02, 32'h12345678, 32'hDEADBEEF, 8'h01, 0, 1'b1, 9'd2, 32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{8'h01, 32'hCAFEF00D, 32'h00000000, 8'h00, 1, 1'b0, 9'd1, 32'hCAFEF00D, 32'hDEADBEEF};
        vecs[3] = '{8'h02, 32'hA5A5A5A5, 32'h0000A501, 8'h00, 1, 1'b0, 9'd2, 32'hA5A5A5A5, 32'h0000A501};

        fetch_if.rd_addr = 8'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_out), 32'(IDLE));
        check("rst_busy", 32'(prog_busy), 32'd0);
        check("rst_done", 32'(prog_done), 32'd0);
        check("rst_err", 32'(prog_err), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Noise before a frame: non-sync bytes and a start glitch shorter
        // than half a bit must leave the loader idle.
        send_byte(8'h00);
        send_byte(8'h55);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("noise_state", 32'(state_out), 32'(IDLE));
        check("noise_busy", 32'(prog_busy), 32'd0);
        check("noise_err", 32'(prog_err), 32'd0);
        check("noise_words", 32'(words_loaded), 32'd0);

        for (int i = 0; i < 4; i++) apply_vec(vecs[i], i);

        // Framing error on the third data byte.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_bits(8'h56);
        uart_rx = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3 * CPB && !found; i++) begin
            @(negedge clk);
            if (dut.rx_ferr) found = 1'b1;
        end
        check("ferr_seen", 32'(found), 32'd1);
        @(negedge clk);
        check("ferr_state", 32'(state_out), 32'(IDLE));
        check("ferr_busy", 32'(prog_busy), 32'd0);
        check("ferr_err", 32'(prog_err), 32'd1);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("ferr_words", 32'(words_loaded), 32'd0);
        rd(8'd0, d);
        check("ferr_mem0_kept", d, 32'hA5A5A5A5);
        apply_vec(vecs[0], 4);

        // Full-depth image: N = 0, word i = i.
        d0 = done_cnt;
        send_byte(8'hA5);
        tb_csum = 8'h00;
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_word(32'(i));
        send_byte(tb_csum);
        repeat (3) @(negedge clk);
        check("full_done", 32'(done_cnt - d0), 32'd1);
        check("full_err", 32'(prog_err), 32'd0);
        check("full_words", 32'(words_loaded), 32'd256);
        rd(8'hFF, d);
        check("full_mem255", d, 32'h000000FF);
        rd(8'h00, d);
        check("full_mem0", d, 32'h00000000);
        rd(8'h80, d);
        check("full_mem128", d, 32'h00000080);

        // Reset pulsed mid-GET_DATA, between bytes.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (2) @(negedge clk);
        check("mid_state", 32'(state_out), 32'(GET_DATA));
        check("mid_words", 32'(words_loaded), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state_out), 32'(IDLE));
        check("arst_busy", 32'(prog_busy), 32'd0);
        check("arst_err", 32'(prog_err), 32'd0);
        check("arst_done", 32'(prog_done), 32'd0);
        check("arst_words", 32'(words_loaded), 32'd0);
        rd(8'd0, d);
        check("arst_mem0_kept", d, 32'h11223344);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        apply_vec(vecs[0], 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Upstream stage of the tiny FSM controller. Receives a framed program image over UART, assembles 32-bit instruction words, and writes them into an internal instruction memory.
- Serves the controller's fetch port: the controller drives rd_addr, and this block returns rd_data combinationally.
- Asserts prog_busy while a load is in progress. The top level ORs prog_busy into the controller's reset, so the controller never fetches a partially written image.

Parameters:
- F_CLK, 50_000_000, system clock frequency in Hz.
- BAUD, 921_600, UART bit rate.
- CLK_PER_BIT, F_CLK/BAUD (54), clocks per UART bit.
- INSTR_WIDTH, 32, instruction word width; must be a multiple of 8.
- INSTR_DEPTH, 256, instruction memory depth in words.
- PC_WIDTH, $clog2(INSTR_DEPTH), address width.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input; idles high; asynchronous to clk.
- rd_addr  in  PC_WIDTH  fetch address from the controller.
- rd_data  out  INSTR_WIDTH  mem[rd_addr], combinational read.
- prog_busy  out  1  high from SYNC_BYTE accepted until the frame ends.
- prog_done  out  1  one-cycle pulse when a frame commits with a good checksum.
- prog_err  out  1  sticky error flag; cleared when the next SYNC_BYTE is accepted.
- words_loaded  out  PC_WIDTH+1  count of words written in the current or last frame.
- state_out  out  3  loader state, for debug.

Behaviour:
- Reset
  - One clock domain; reset is asynchronous and active-low.
  - On reset: state = IDLE, prog_busy = 0, prog_done = 0, prog_err = 0, words_loaded = 0, byte counter = 0, checksum = 0, RX block idle.
  - Memory contents are not reset.
- RX sub-block
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge in idle starts a byte. The line is re-checked at CLK_PER_BIT/2; if it is high again, the start is treated as a glitch and the RX block returns to idle.
  - Data bits are sampled every CLK_PER_BIT, LSB first. The stop bit is sampled one bit-time after bit 7.
  - Stop bit = 1: rx_valid pulses for 1 cycle with rx_byte.
  - Stop bit = 0: rx_ferr pulses instead and no byte is delivered.
- Frame format: SYNC_BYTE, N, then N×(INSTR_WIDTH/8) data bytes MSB-first, then CSUM.
  - N = 0 means INSTR_DEPTH words.
  - CSUM = XOR of N and all data bytes.
- Loader states:
  - IDLE: bytes other than SYNC_BYTE are ignored. On SYNC_BYTE: go to GET_COUNT, set prog_busy = 1, clear prog_err, words_loaded and checksum.
  - GET_COUNT: latch N, checksum ^= N, go to GET_DATA.
  - GET_DATA:
    - Each byte shifts into the word register and updates the checksum.
    - On the last byte of a word: write mem[wr_addr] <= {shift, byte} on the same cycle as that rx_valid; increment wr_addr and words_loaded.
    - When words_loaded reaches N, go to GET_CSUM.
    - wr_addr starts at 0 for every frame.
  - GET_CSUM: if the byte equals the checksum, pulse prog_done; otherwise set prog_err. In both cases go to IDLE and clear prog_busy on the next cycle.
- Error handling
  - rx_ferr in any non-IDLE state: set prog_err and go to IDLE immediately.
  - Words already written stay in memory; memory is not rolled back.
- Read port
  - rd_data = mem[rd_addr], combinational, so the controller's fetch completes in the same cycle.
  - A write and a read to the same address in the same cycle return the old data.
- Address width: wr_addr is PC_WIDTH bits. With N = 0 the last write lands at INSTR_DEPTH-1 and no wrap write occurs. words_loaded uses PC_WIDTH+1 bits so it can hold 256.
- SYNC_BYTE mid-frame: treated as ordinary data; the frame does not restart.

Decomposition:
- Package imem_loader_pkg:
  - loader_state_t enum {IDLE, GET_COUNT, GET_DATA, GET_CSUM}.
  - SYNC_BYTE default.
  - BYTES_PER_WORD = INSTR_WIDTH/8.
- One sub-module: uart_rx
  - Contains the synchronizer, bit timer and the start, data and stop phases.
  - Outputs rx_valid, rx_byte, rx_ferr.
- The memory array is inferred inside uart_imem_loader.

Test Plan:
- Basic load: send A5, 02, 12 34 56 78, DE AD BE EF, CSUM = 02^12^34^56^78^DE^AD^BE^EF. Required: prog_done pulses once, mem[0] = 32'h12345678, mem[1] = 32'hDEADBEEF, words_loaded = 2, prog_err = 0, prog_busy low afterwards.
- Bad checksum: same frame with CSUM ^ 8'h01. Required: prog_err = 1, no prog_done, mem[0..1] still written. A following good frame clears prog_err.
- Framing error: drive the stop bit to 0 on the third data byte. Required: prog_err = 1, state returns to IDLE within 1 cycle, prog_busy = 0.
- Full depth: N = 00 followed by 1024 bytes where word i = i. Required: words_loaded = 256, mem[255] = 255, rd_addr = 8'hFF returns 32'h000000FF in the same cycle.
- Noise and glitches:
  - 0x00, 0x55 and a 10-cycle low glitch before A5. Required: no state change; the following frame loads normally.
  - rst_n pulsed low mid-GET_DATA. Required: all outputs immediately return to reset values, and the next frame loads normally.
